sram_fifo: RTL and testbench

//  Synchronous FIFO whose storage is a sram_1r1w instance (READ_DURING_WRITE "DONT_CARE").
//  It issues its own SRAM reads and never reads an address in the same cycle that address is written.
//  The dequeue side is a show-ahead valid/ready stream fed by a 2-entry output stage.
//  It absorbs the 1-cycle SRAM read latency, so sustained throughput is 1 word/cycle.

---
 rtl/sram_fifo_if.sv | 36 +++
 rtl/sram_fifo.sv | 122 ++++++++++++
 tb/tb_sram_fifo.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_if.sv
// sram_fifo_if: handshake bundle for sram_fifo.
//   master : producer/consumer side (drives flush, enqueue_*, dequeue_ready)
//   slave  : the FIFO (drives full, almost_full, dequeue_valid/value, count)
//   flush         - synchronous clear of all contents
//   enqueue_en    - push enqueue_value this cycle (ignored while full)
//   full          - count == SIZE
//   almost_full   - count >= ALMOST_FULL
//   dequeue_valid - dequeue_value holds the oldest entry
//   dequeue_ready - consumer accepts; pop = valid & ready
//   count         - entries accepted and not yet popped
interface sram_fifo_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
);
  localparam int ADDR_WIDTH = $clog2(SIZE);

  logic                  flush;
  logic                  enqueue_en;
  logic [WIDTH-1:0]      enqueue_value;
  logic                  full;
  logic                  almost_full;
  logic                  dequeue_valid;
  logic                  dequeue_ready;
  logic [WIDTH-1:0]      dequeue_value;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output flush, enqueue_en, enqueue_value, dequeue_ready,
    input  full, almost_full, dequeue_valid, dequeue_value, count
  );

  modport slave (
    input  flush, enqueue_en, enqueue_value, dequeue_ready,
    output full, almost_full, dequeue_valid, dequeue_value, count
  );
endinterface

// File: rtl/sram_fifo.sv
// sram_fifo: deep synchronous FIFO built on a 1R1W SRAM with a 1-cycle
// registered read, followed by a 2-entry show-ahead output stage so the
// consumer sees one word per cycle with no bubbles.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   q     - sram_fifo_if.slave (push side, pop side, flush, status)
// Build option:
//   SRAM_FIFO_BYPASS_EN - when the SRAM holds nothing, a push skips the SRAM
//                         and goes straight into the read-data register,
//                         cutting push-to-valid latency from 2 to 1.
module sram_fifo #(
  parameter int WIDTH       = 32,
  parameter int SIZE        = 64,
  parameter int ADDR_WIDTH  = $clog2(SIZE),
  parameter int ALMOST_FULL = SIZE - 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_fifo_if.slave  q
);

  localparam int              CW     = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   SIZE_C = CW'(SIZE);
  localparam logic [CW-1:0]   AF_C   = CW'(ALMOST_FULL);

  // SRAM array (read-during-write to one address is undefined; never used)
  logic [WIDTH-1:0]      mem [SIZE];

  logic [ADDR_WIDTH-1:0] head_p0, tail_p0;
  logic [CW-1:0]         sram_cnt_p0;   // committed entries not yet read
  logic [CW-1:0]         count_p0;
  logic                  full_p0, afull_p0;

  logic                  vld_p1;
  logic [WIDTH-1:0]      rd_data_p1;

  logic [1:0]            out_cnt_p2;
  logic [WIDTH-1:0]      out0_p2, out1_p2;

  logic                  push, pop, room, issue, bypass, wr_en;
  logic [1:0]            out_left;
  logic [CW-1:0]         count_nxt;

  always_comb begin
    push      = q.enqueue_en & ~full_p0;
    pop       = (out_cnt_p2 != 2'd0) & q.dequeue_ready;
    out_left  = out_cnt_p2 - {1'b0, pop};
    // Output stage has room for one more word once this cycle's pop and the
    // word already sitting in the read-data register are accounted for.
    room      = (out_left + {1'b0, vld_p1}) < 2'd2;
    // Entries in the SRAM were written on an earlier edge, and head can only
    // equal tail when the SRAM holds SIZE entries (then no push is accepted),
    // so the read address never collides with the write address.
    issue     = (sram_cnt_p0 != '0) & room & ~q.flush;
`ifdef SRAM_FIFO_BYPASS_EN
    bypass    = push & (sram_cnt_p0 == '0) & room & ~q.flush;
`else
    bypass    = 1'b0;
`endif
    wr_en     = push & ~bypass & ~q.flush;
    count_nxt = count_p0 + CW'(push) - CW'(pop);
  end

  // ---- stage p0 -> p1: SRAM write and read issue ----
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_p0] <= q.enqueue_value;
    if (issue)       rd_data_p1 <= mem[head_p0];
    else if (bypass) rd_data_p1 <= q.enqueue_value;
  end

  // ---- stage p1 -> p2: output stage load ----
  // The arriving word lands in the first free slot after the pop; on a pop
  // with both slots occupied the skid word shifts forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           out0_p2 <= '0;
    else if (vld_p1 && out_left == 2'd0)  out0_p2 <= rd_data_p1;
    else if (pop && out_cnt_p2 == 2'd2)   out0_p2 <= out1_p2;
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && out_left == 2'd1) out1_p2 <= rd_data_p1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_p0     <= '0;
      tail_p0     <= '0;
      sram_cnt_p0 <= '0;
      count_p0    <= '0;
      full_p0     <= 1'b0;
      afull_p0    <= 1'b0;
      vld_p1      <= 1'b0;
      out_cnt_p2  <= 2'd0;
    end else if (q.flush) begin
      head_p0     <= '0;
      tail_p0     <= '0;
      sram_cnt_p0 <= '0;
      count_p0    <= '0;
      full_p0     <= 1'b0;
      afull_p0    <= 1'b0;
      vld_p1      <= 1'b0;
      out_cnt_p2  <= 2'd0;
    end else begin
      if (wr_en) tail_p0 <= tail_p0 + 1'b1;
      if (issue) head_p0 <= head_p0 + 1'b1;
      sram_cnt_p0 <= sram_cnt_p0 + CW'(wr_en) - CW'(issue);
      count_p0    <= count_nxt;
      full_p0     <= (count_nxt == SIZE_C);
      afull_p0    <= (count_nxt >= AF_C);
      vld_p1      <= issue | bypass;
      out_cnt_p2  <= out_left + {1'b0, vld_p1};
    end
  end

  assign q.full          = full_p0;
  assign q.almost_full   = afull_p0;
  assign q.count         = count_p0;
  assign q.dequeue_valid = (out_cnt_p2 != 2'd0);
  assign q.dequeue_value = out0_p2;

endmodule

// File: tb/tb_sram_fifo.sv
// tb_sram_fifo: directed and randomized bench for sram_fifo with a queue
// reference model; a negedge monitor compares every pop and the status
// outputs against the model.
module tb_sram_fifo;
  localparam int WIDTH = 32;
  localparam int SIZE  = 64;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_fifo_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();
  sram_fifo #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (.clk(clk), .rst_n(rst_n), .q(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] expq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic [WIDTH-1:0] v, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    bus.enqueue_en    = en;
    bus.enqueue_value = v;
    bus.dequeue_ready = rdy;
    bus.flush         = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model and monitor: the queue holds every accepted, unpopped
  // word; pushes and pops seen here take effect on the coming edge.
  always @(negedge clk) begin
    int n;
    logic [WIDTH-1:0] e;
    if (!rst_n) begin
      expq.delete();
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_valid", 64'(bus.dequeue_valid), 64'd0);
      chk("rst_full",  64'(bus.full), 64'd0);
    end else begin
      n = expq.size();
      chk("count", 64'(bus.count), 64'(n));
      chk("full", 64'(bus.full), 64'(n == SIZE));
      chk("almost_full", 64'(bus.almost_full), 64'(n >= SIZE - 4));
      if (n == 0) chk("valid_when_empty", 64'(bus.dequeue_valid), 64'd0);
      if (bus.flush) begin
        expq.delete();
      end else begin
        if (bus.dequeue_valid && bus.dequeue_ready) begin
          if (n == 0) begin
            chk("pop_from_empty", 64'd1, 64'd0);
          end else begin
            e = expq.pop_front();
            chk("pop_data", 64'(bus.dequeue_value), 64'(e));
          end
        end
        if (bus.enqueue_en && n < SIZE) expq.push_back(bus.enqueue_value);
      end
    end
  end

  initial begin
    bus.flush = 1'b0;
    bus.enqueue_en = 1'b0;
    bus.enqueue_value = '0;
    bus.dequeue_ready = 1'b0;

    // Reset values
    #2;
    chk("rst_almost_full", 64'(bus.almost_full), 64'd0);
    chk("rst_value", 64'(bus.dequeue_value), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: single push latency
    drive(1'b1, 32'h245fa7d4, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);            // returns after E0
    @(negedge clk);
    chk("t1_valid_e0", 64'(bus.dequeue_valid), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);            // after E1
    @(negedge clk);
    chk("t1_valid_e1", 64'(bus.dequeue_valid), 64'(LAT == 1));
    drive(1'b0, '0, 1'b0, 1'b0);            // after E2
    @(negedge clk);
    chk("t1_valid_e2", 64'(bus.dequeue_valid), 64'd1);
    chk("t1_value", 64'(bus.dequeue_value), 64'h245fa7d4);
    chk("t1_count", 64'(bus.count), 64'd1);

    // Test 2: fill to full with backpressure, overflow push, then drain
    do_reset();
    for (int i = 0; i < SIZE; i++) begin
      drive(1'b1, WIDTH'(i * 3 + 1), 1'b0, 1'b0);
      @(negedge clk);
      chk("t2_afull_ramp", 64'(bus.almost_full), 64'(i >= SIZE - 4));
    end
    drive(1'b1, 32'hdead0065, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_full", 64'(bus.full), 64'd1);
    chk("t2_afull", 64'(bus.almost_full), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_overflow_count", 64'(bus.count), 64'(SIZE));
    for (int i = 0; i < SIZE; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t2_drain_valid", 64'(bus.dequeue_valid), 64'd1);
      chk("t2_drain_value", 64'(bus.dequeue_value), 64'(i * 3 + 1));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_final_count", 64'(bus.count), 64'd0);

    // Test 3: streaming push and pop every cycle
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0);
      @(negedge clk);
      if (i >= LAT + 1) begin
        chk("t3_no_bubble", 64'(bus.dequeue_valid), 64'd1);
        chk("t3_steady_count", 64'(bus.count), 64'(LAT + 1));
        chk("t3_value", 64'(bus.dequeue_value), 64'(i - LAT - 1));
      end
    end
    drive(1'b0, '0, 1'b1, 1'b1);

    // Test 4: push and pop together while full
    do_reset();
    for (int i = 0; i < SIZE; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'h0bad0bad, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_count", 64'(bus.count), 64'(SIZE - 1));
    chk("t4_full", 64'(bus.full), 64'd0);

    // Test 5: flush wins over a concurrent push and pop
    do_reset();
    drive(1'b1, 32'h07b8261b, 1'b0, 1'b0);
    drive(1'b1, 32'h47b06ea2, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_pending_valid", 64'(bus.dequeue_valid), 64'd1);
    drive(1'b1, 32'hdff64bb1, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_valid", 64'(bus.dequeue_valid), 64'd0);
    repeat (5) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t5_never_out", 64'(bus.dequeue_valid), 64'd0);
    end

    // Test 6: random traffic with a mid-run asynchronous reset
    for (int c = 0; c < 5000; c++) begin
      if (c == 2500) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", 64'(bus.count), 64'd0);
        chk("t6_async_valid", 64'(bus.dequeue_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 299) == 0));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
